// File: rtl/spike_encoder.sv
// Spike encoder: converts an unsigned intensity into a WINDOW-slot spike train,
// using either rate coding (accumulator overflow) or time-to-first-spike latency coding.
module spike_encoder #(
    parameter  int DATA_W = 8,
    parameter  int WINDOW = 16,
    localparam int CNT_W  = $clog2(WINDOW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_mode,
    input  logic              abort,
    output logic              spike_out,
    output logic              busy,
    output logic              window_done,
    output logic [CNT_W:0]    spike_count
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  slot_q, slot_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              mode_q, mode_d;
    logic [CNT_W:0]    cnt_q, cnt_d;
    logic              spike_out_q, spike_out_d;
    logic              busy_q, busy_d;
    logic              window_done_q, window_done_d;
    logic [CNT_W:0]    spike_count_q, spike_count_d;

    logic              accept, last, spike, running;
    logic [DATA_W:0]   sum;
    logic [CNT_W-1:0]  target;

    always_comb begin
        running  = (state_q == RUN);
        last     = (slot_q == CNT_W'(WINDOW - 1));
        in_ready = (!running || last) && !abort;
        accept   = in_valid && in_ready;
        sum      = {1'b0, acc_q} + {1'b0, value_q};
        // Brighter inputs fire earlier: slot index is the top CNT_W bits of the inverted value.
        target   = CNT_W'((~value_q) >> (DATA_W - CNT_W));
        spike    = running && (mode_q ? ((value_q != '0) && (slot_q == target))
                                      : sum[DATA_W]);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (abort)     state_d = IDLE;
                else if (last) state_d = accept ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        slot_d        = slot_q;
        acc_d         = acc_q;
        value_d       = value_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        spike_out_d   = spike && !abort;
        window_done_d = running && last && !abort;
        spike_count_d = spike_count_q;
        busy_d        = (state_d == RUN);

        if (running && last && !abort)
            spike_count_d = cnt_q + (CNT_W+1)'(spike);

        if (accept) begin
            value_d = in_value;
            mode_d  = in_mode;
            slot_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (running && abort) begin
            slot_d = '0;
            acc_d  = '0;
        end else if (running) begin
            slot_d = slot_q + 1'b1;
            acc_d  = mode_q ? acc_q : sum[DATA_W-1:0];
            cnt_d  = cnt_q + (CNT_W+1)'(spike);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q        <= '0;
            acc_q         <= '0;
            value_q       <= '0;
            mode_q        <= 1'b0;
            cnt_q         <= '0;
            spike_out_q   <= 1'b0;
            busy_q        <= 1'b0;
            window_done_q <= 1'b0;
            spike_count_q <= '0;
        end else begin
            slot_q        <= slot_d;
            acc_q         <= acc_d;
            value_q       <= value_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            spike_out_q   <= spike_out_d;
            busy_q        <= busy_d;
            window_done_q <= window_done_d;
            spike_count_q <= spike_count_d;
        end
    end

    assign spike_out   = spike_out_q;
    assign busy        = busy_q;
    assign window_done = window_done_q;
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder (DATA_W=8, WINDOW=16): rate/latency windows,
// back-to-back accept, abort and mid-window reset.
module tb_spike_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic       in_mode;
    logic       abort;
    logic       spike_out;
    logic       busy;
    logic       window_done;
    logic [4:0] spike_count;

    int errs   = 0;
    int checks = 0;

    spike_encoder #(.DATA_W(8), .WINDOW(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_mode(in_mode), .abort(abort),
        .spike_out(spike_out), .busy(busy), .window_done(window_done),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge (1..16 after accept) at which a spike is expected.
    function automatic bit exp_spike(input int v, input bit mode, input int e);
        int k;
        k = e - 1;
        if (mode) return (v != 0) && (e == ((255 - v) >> 4) + 1);
        return (((k + 1) * v) >> 8) != ((k * v) >> 8);
    endfunction

    function automatic int exp_total(input int v, input bit mode);
        if (mode) return (v != 0) ? 1 : 0;
        return (v * 16) >> 8;
    endfunction

    // Called right after the accepting edge (time = edge + 1).
    task automatic observe_window(input string tag, input int v, input bit mode);
        int seen;
        seen = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (spike_out !== exp_spike(v, mode, e))
                chk({tag, "_spike"}, spike_out, exp_spike(v, mode, e));
            if (spike_out === 1'b1) seen++;
            if (e < 16 && window_done !== 1'b0) chk({tag, "_early_done"}, window_done, 0);
            if (e < 16 && busy !== 1'b1) chk({tag, "_busy_mid"}, busy, 1);
        end
        chk({tag, "_pulses"}, seen, exp_total(v, mode));
        chk({tag, "_done"}, window_done, 1);
        chk({tag, "_count"}, spike_count, exp_total(v, mode));
        chk({tag, "_busy_end"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, window_done, 0);
        chk({tag, "_spike_idle"}, spike_out, 0);
    endtask

    task automatic run_window(input string tag, input int v, input bit mode);
        in_value = 8'(v);
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = ~8'(v);      // later input changes must not disturb the window
        in_mode  = ~mode;
        observe_window(tag, v, mode);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_value = '0; in_mode = 1'b0; abort = 1'b0;
        #12;
        chk("rst_spike", spike_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", window_done, 0);
        chk("rst_count", spike_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 1);

        run_window("rate128", 128, 1'b0);
        run_window("rate255", 255, 1'b0);
        run_window("rate0",   0,   1'b0);
        run_window("rate37",  37,  1'b0);
        run_window("lat200",  200, 1'b1);
        run_window("lat255",  255, 1'b1);
        run_window("lat1",    1,   1'b1);
        run_window("lat0",    0,   1'b1);

        // Back-to-back: 128 then 64 with in_valid held high.
        in_value = 8'd128; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_ready_s0", in_ready, 0);
        in_value = 8'd64;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); #1;
            if (spike_out !== exp_spike(128, 1'b0, e)) chk("b2b_w1_spike", spike_out, exp_spike(128, 1'b0, e));
        end
        chk("b2b_ready_s15", in_ready, 1);
        @(posedge clk); #1;   // E16: second sample accepted
        in_valid = 1'b0;
        chk("b2b_w1_spike16", spike_out, 1);
        chk("b2b_w1_done", window_done, 1);
        chk("b2b_w1_count", spike_count, 8);
        chk("b2b_busy", busy, 1);
        observe_window("b2b_w2", 64, 1'b0);

        // Abort at slot 5 with in_valid high.
        in_value = 8'd255; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 1; e <= 5; e++) begin @(posedge clk); #1; end
        abort = 1'b1; in_valid = 1'b1; in_value = 8'd128;
        #1 chk("abort_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_spike", spike_out, 0);
        chk("abort_done", window_done, 0);
        chk("abort_count", spike_count, 4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_reaccept", busy, 1);
        observe_window("post_abort", 128, 1'b0);

        // Reset pulsed during slot 7 of a rate-255 window.
        in_value = 8'd255; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 1; e <= 7; e++) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_spike", spike_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", window_done, 0);
        chk("mid_rst_count", spike_count, 0);
        #1 reset = 1'b0;
        run_window("post_rst", 128, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameter DATA_W, default 8, width of the input intensity value.
REQ-002 Parameter WINDOW, default 16, slots per encoding window; power of two, 2 <= WINDOW <= 2^DATA_W; CNT_W = log2(WINDOW).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_value/in_mode hold a sample.
REQ-006 in_ready  output  1  combinational: (IDLE or RUN with slot == WINDOW-1) and abort low.
REQ-007 in_value  input  DATA_W  intensity, unsigned.
REQ-008 in_mode  input  1  0 = rate coding, 1 = latency (time-to-first-spike) coding.
REQ-009 abort  input  1  synchronous cancel of the current window.
REQ-010 spike_out  output  1  registered spike train, one-cycle pulses, drives downstream neuron spike inputs.
REQ-011 busy  output  1  registered, high while state == RUN.
REQ-012 window_done  output  1  registered one-cycle pulse at window completion.
REQ-013 spike_count  output  CNT_W+1  registered, spikes emitted in last completed window.

Function
REQ-014 States IDLE and RUN; accept = in_valid and in_ready; accept latches in_value, in_mode, sets slot = 0, acc = 0, state = RUN.
REQ-015 Slot k (0..WINDOW-1) is the k-th clock cycle in RUN after the accepting edge; slot counter increments each RUN cycle.
REQ-016 Rate mode: sum = acc + value at DATA_W+1 bits; slot spikes when sum[DATA_W] = 1; acc <= sum[DATA_W-1:0].
REQ-017 Rate mode total spikes per window = floor(value * WINDOW / 2^DATA_W).
REQ-018 Latency mode: exactly one spike at slot k = (2^DATA_W-1 - value) >> (DATA_W - CNT_W) when value != 0; value == 0 gives no spike.
REQ-019 spike_out is high in the cycle after slot k iff slot k spikes (1-cycle latency); low otherwise, including all IDLE cycles.
REQ-020 Internal spike counter cleared on accept, incremented per spiking slot; spike_count loads final total at the edge ending slot WINDOW-1, otherwise holds.
REQ-021 window_done is high for one cycle after the edge ending slot WINDOW-1, coincident with that slot's spike_out.
REQ-022 End of slot WINDOW-1: if accept, restart RUN at slot 0 with new sample (no idle gap); else go IDLE.
REQ-023 Back-to-back windows: old window's last spike_out/window_done coexists with new window's slot 0; no interference.
REQ-024 abort high in RUN: next edge goes IDLE, spike_out = 0, no window_done, spike_count unchanged, no accept that cycle (abort wins over in_valid).
REQ-025 abort in IDLE has no effect other than masking in_ready.
REQ-026 in_value/in_mode changes after accept have no effect on the current window.

Reset
REQ-027 reset high: state = IDLE, slot = 0, acc = 0, spike_out = 0, busy = 0, window_done = 0, spike_count = 0, immediately and asynchronously.
REQ-028 reset mid-window discards the window; no window_done; first accept possible on first edge after reset deasserts.

Verification
REQ-029 Rate, value=128, accept at edge E0 -> spike_out high after E2,E4,...,E16 (8 pulses), window_done and spike_count=8 after E16, busy low after E16.
REQ-030 Rate, value=255 -> 15 pulses (after E2..E16), spike_count=15; value=0 -> no pulses, window_done after E16, spike_count=0.
REQ-031 Latency, value=200 -> single pulse after E4 (slot 3); value=255 -> after E1; value=1 -> after E16; value=0 -> none, spike_count=0.
REQ-032 in_valid held, samples 128 then 64 (rate) -> in_ready high during slot 15, second accepted at E16, window_done after E16 and E32, spike_count 8 then 4, busy continuously high.
REQ-033 Abort at slot 5 with in_valid high -> busy/spike_out low after that edge, no window_done, spike_count keeps prior value, next sample accepted one cycle later.
REQ-034 reset pulsed at slot 7 of rate value=255 -> all outputs 0 immediately, no window_done; new sample after release encodes normally.
